// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs symbolic MIPS instruction requests into 32-bit
// words, buffers them in a small FIFO and streams them into instruction
// memory at consecutive word addresses starting from BASE_ADDR.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for the first request of a program
//   LOAD  | accepting requests while the FIFO has room
//   DRAIN | last request taken; flushing FIFO and output register
//   DONE  | one-cycle completion pulse, then back to IDLE
module mips_instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic              imem_stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic              addr_wrap
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   word;
  logic          op_ok;
  logic          is_r, shift_imm;
  logic [5:0]    funct, opcode;
  logic          accept, push, pop, wr_done;

  // Encode the incoming request into a MIPS word and flag unsupported selectors.
  always_comb begin
    funct     = 6'h00;
    opcode    = 6'h00;
    is_r      = 1'b0;
    shift_imm = 1'b0;
    op_ok     = 1'b1;
    case (op_sel)
      5'd0:  begin is_r = 1'b1; funct = 6'h20; end
      5'd1:  begin is_r = 1'b1; funct = 6'h21; end
      5'd2:  begin is_r = 1'b1; funct = 6'h22; end
      5'd3:  begin is_r = 1'b1; funct = 6'h23; end
      5'd4:  begin is_r = 1'b1; funct = 6'h24; end
      5'd5:  begin is_r = 1'b1; funct = 6'h25; end
      5'd6:  begin is_r = 1'b1; funct = 6'h26; end
      5'd7:  begin is_r = 1'b1; funct = 6'h27; end
      5'd8:  begin is_r = 1'b1; funct = 6'h2a; end
      5'd9:  begin is_r = 1'b1; funct = 6'h00; shift_imm = 1'b1; end
      5'd10: begin is_r = 1'b1; funct = 6'h04; end
      5'd11: begin is_r = 1'b1; funct = 6'h02; shift_imm = 1'b1; end
      5'd12: begin is_r = 1'b1; funct = 6'h06; end
      5'd13: begin is_r = 1'b1; funct = 6'h03; shift_imm = 1'b1; end
      5'd14: begin is_r = 1'b1; funct = 6'h07; end
      5'd15: opcode = 6'h04;
      5'd16: opcode = 6'h05;
      5'd17: opcode = 6'h23;
      5'd18: opcode = 6'h2b;
      5'd19: opcode = 6'h08;
      5'd20: opcode = 6'h09;
      5'd21: opcode = 6'h0c;
      5'd22: opcode = 6'h0d;
      5'd23: opcode = 6'h0e;
      default: op_ok = 1'b0;
    endcase
    if (is_r)
      word = {6'h00, (shift_imm ? 5'd0 : rs), rt, rd, (shift_imm ? shamt : 5'd0), funct};
    else
      word = {opcode, rs, rt, imm};
  end

  assign accept  = in_valid && in_ready;
  assign push    = accept && op_ok;
  assign pop     = (count != '0) && (!imem_we || !imem_stall);
  assign wr_done = imem_we && !imem_stall;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and handshake/completion outputs from registered state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? DRAIN : LOAD;
      end
      LOAD: begin
        in_ready = (count < FULL);
        if (in_valid && (count < FULL) && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((count == '0) && !imem_we) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // FIFO pointers, output register, address counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= 32'h0;
      err        <= 1'b0;
      addr_wrap  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        imem_wdata <= mem[rd_ptr];
        imem_we    <= 1'b1;
      end else if (wr_done) begin
        imem_we    <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);

      if (accept) begin
        if (state == IDLE) begin
          err       <= !op_ok;
          addr_wrap <= 1'b0;
        end else if (!op_ok) begin
          err       <= 1'b1;
        end
      end

      // The output register is always empty in IDLE, so the restart never
      // collides with a completing write.
      if (accept && (state == IDLE)) begin
        imem_addr <= BASE;
      end else if (wr_done) begin
        imem_addr <= imem_addr + 1'b1;
        if (imem_addr == '1) addr_wrap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Testbench for mips_instr_encoder: two instances (default parameters and a
// narrow-address instance with a non-zero base) share one request stream and
// are checked against a word-level reference model.
module tb_mips_instr_encoder;

  logic        clk, reset, in_valid, in_last, imem_stall;
  logic [4:0]  op_sel, rs, rt, rd, shamt;
  logic [15:0] imm;

  logic        ready0, we0, done0, err0, wrap0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic        ready1, we1, done1, err1, wrap1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int cyc      = 0;

  logic [31:0] exp_words[$];
  logic [31:0] got_words[$];
  int          wr_cyc[$];
  int          wr_cnt0, wr_cnt1, done_cnt0;
  bit          exp_err, exp_wrap0, exp_wrap1;
  bit          rand_stall = 0;

  bit          prev_we0, prev_stall, prev_rst;
  logic [7:0]  prev_addr0;
  logic [31:0] prev_wdata0;

  mips_instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready0), .in_last(in_last),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .imem_stall(imem_stall), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
    .done(done0), .err(err0), .addr_wrap(wrap0));

  mips_instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready1), .in_last(in_last),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .imem_stall(imem_stall), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .done(done1), .err(err1), .addr_wrap(wrap1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, observed running required finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference encoder built directly from the instruction tables.
  function automatic logic [31:0] ref_word(input int op, input int r_s, input int r_t,
                                           input int r_d, input int sh, input int im);
    int funct [15];
    int opc [9];
    longint w;
    bit shift_imm;
    funct = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a,
              'h00, 'h04, 'h02, 'h06, 'h03, 'h07};
    opc   = '{'h04, 'h05, 'h23, 'h2b, 'h08, 'h09, 'h0c, 'h0d, 'h0e};
    if (op < 15) begin
      shift_imm = (op == 9) || (op == 11) || (op == 13);
      w = longint'(shift_imm ? 0 : r_s) * 2097152 + longint'(r_t) * 65536 +
          longint'(r_d) * 2048 + longint'(shift_imm ? sh : 0) * 64 + longint'(funct[op]);
    end else begin
      w = longint'(opc[op-15]) * 67108864 + longint'(r_s) * 2097152 +
          longint'(r_t) * 65536 + longint'(im);
    end
    return 32'(w);
  endfunction

  task automatic start_prog();
    exp_words.delete();
    got_words.delete();
    wr_cyc.delete();
    wr_cnt0   = 0;
    wr_cnt1   = 0;
    done_cnt0 = 0;
    exp_err   = 0;
    exp_wrap0 = 0;
    exp_wrap1 = 0;
  endtask

  task automatic send(input int op, input int r_s, input int r_t, input int r_d,
                      input int sh, input int im, input bit last);
    bit got = 0;
    op_sel = 5'(op); rs = 5'(r_s); rt = 5'(r_t); rd = 5'(r_d);
    shamt = 5'(sh); imm = 16'(im); in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ready0) got = 1;
    end
    if (got) begin
      @(posedge clk);
      n_acc++;
      if (op < 24) exp_words.push_back(ref_word(op, r_s, r_t, r_d, sh, im));
      else         exp_err = 1;
      #1;
    end else begin
      chk("send_timeout", 32'(got), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_prog();
    bit seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (done0) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done1_seen", 32'(done1), 32'(seen));
    @(negedge clk);
    chk("done_one_cycle", 32'(done0), 32'd0);
    chk("idle_ready", 32'(ready0), 32'd1);
    chk("idle_we", 32'(we0), 32'd0);
    chk("write_count0", 32'(wr_cnt0), 32'(exp_words.size()));
    chk("write_count1", 32'(wr_cnt1), 32'(exp_words.size()));
    chk("done_pulses", 32'(done_cnt0), 32'd1);
    chk("err0", 32'(err0), 32'(exp_err));
    chk("err1", 32'(err1), 32'(exp_err));
    chk("wrap0_end", 32'(wrap0), 32'(exp_wrap0));
    chk("wrap1_end", 32'(wrap1), 32'(exp_wrap1));
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every completed write must match the next expected word and address.
  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_match", 32'(ready1), 32'(ready0));
      if (we0 && !imem_stall) begin
        if (wr_cnt0 < exp_words.size()) chk("wdata0", wdata0, exp_words[wr_cnt0]);
        else                            chk("extra_write0", 32'd1, 32'd0);
        chk("addr0", 32'(addr0), 32'(wr_cnt0 % 256));
        chk("wrap0", 32'(wrap0), 32'(exp_wrap0));
        if ((wr_cnt0 % 256) == 255) exp_wrap0 = 1;
        got_words.push_back(wdata0);
        wr_cyc.push_back(cyc);
        wr_cnt0++;
      end
      if (we1 && !imem_stall) begin
        if (wr_cnt1 < exp_words.size()) chk("wdata1", wdata1, exp_words[wr_cnt1]);
        else                            chk("extra_write1", 32'd1, 32'd0);
        chk("addr1", 32'(addr1), 32'((3 + wr_cnt1) % 4));
        chk("wrap1", 32'(wrap1), 32'(exp_wrap1));
        if (((3 + wr_cnt1) % 4) == 3) exp_wrap1 = 1;
        wr_cnt1++;
      end
      if (prev_we0 && prev_stall && !prev_rst) begin
        chk("hold_we", 32'(we0), 32'd1);
        chk("hold_addr", 32'(addr0), 32'(prev_addr0));
        chk("hold_wdata", wdata0, prev_wdata0);
      end
      if (done0) done_cnt0++;
    end
    prev_we0    = we0;
    prev_stall  = imem_stall;
    prev_rst    = reset;
    prev_addr0  = addr0;
    prev_wdata0 = wdata0;
  end

  // Background random stall generator for the random programs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_stall) imem_stall = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; imem_stall = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0;
    start_prog();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready0", 32'(ready0), 32'd1);
    chk("rst_we0", 32'(we0), 32'd0);
    chk("rst_addr0", 32'(addr0), 32'd0);
    chk("rst_addr1", 32'(addr1), 32'd3);
    chk("rst_wdata0", wdata0, 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_wrap1", 32'(wrap1), 32'd0);
    @(posedge clk);
    #1;

    // Single add with latency check
    start_prog();
    send(0, 1, 2, 3, 0, 0, 1);
    @(negedge clk);
    chk("lat_edge_k", 32'(we0), 32'd0);
    @(negedge clk);
    chk("lat_edge_k1", 32'(we0), 32'd1);
    chk("add_wdata", wdata0, 32'h00221820);
    chk("add_addr", 32'(addr0), 32'd0);
    finish_prog();

    // sll / lw / beq stream on consecutive cycles
    start_prog();
    send(9, 7, 1, 2, 4, 0, 0);
    send(17, 29, 8, 0, 0, 8, 0);
    send(15, 1, 2, 0, 0, 'hFFFF, 1);
    finish_prog();
    chk("stream_count", 32'(got_words.size()), 32'd3);
    if (got_words.size() == 3) begin
      chk("sll_word", got_words[0], 32'h00011100);
      chk("lw_word", got_words[1], 32'h8FA80008);
      chk("beq_word", got_words[2], 32'h1022FFFF);
      chk("stream_back_to_back", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
    end

    // Stall for 10 cycles while streaming 8 requests
    start_prog();
    imem_stall = 1'b1;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(i * 3, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 65535), i == 7);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("acc_during_stall", 32'(n_acc), 32'd5);
        chk("ready_low_full", 32'(ready0), 32'd0);
        imem_stall = 1'b0;
      end
    join
    finish_prog();

    // Invalid selector in the middle of a program
    start_prog();
    send(0, 4, 5, 6, 0, 0, 0);
    send(27, 1, 1, 1, 1, 1, 0);
    chk("err_after_invalid", 32'(err0), 32'd1);
    send(2, 7, 8, 9, 3, 0, 1);
    finish_prog();

    // Three requests: the narrow instance writes at 3, 0, 1 and wraps
    start_prog();
    send(19, 1, 2, 0, 0, 100, 0);
    send(5, 3, 4, 5, 0, 0, 0);
    send(23, 6, 7, 0, 0, 'h1234, 1);
    finish_prog();
    chk("wrap_three", 32'(wrap1), 32'd1);

    // Reset asserted in DRAIN with the FIFO non-empty
    start_prog();
    imem_stall = 1'b1;
    send(0, 1, 2, 3, 0, 0, 0);
    send(2, 4, 5, 6, 0, 0, 0);
    send(4, 7, 8, 9, 0, 0, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    imem_stall = 1'b0;
    start_prog();
    @(negedge clk);
    chk("mid_rst_we", 32'(we0), 32'd0);
    chk("mid_rst_ready", 32'(ready0), 32'd1);
    chk("mid_rst_addr0", 32'(addr0), 32'd0);
    chk("mid_rst_addr1", 32'(addr1), 32'd3);
    chk("mid_rst_wdata", wdata0, 32'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_writes", 32'(wr_cnt0), 32'd0);
    chk("mid_rst_no_done", 32'(done_cnt0), 32'd0);
    @(posedge clk);
    #1;
    send(1, 9, 10, 11, 0, 0, 0);
    send(18, 12, 13, 0, 0, 'h0040, 1);
    finish_prog();

    // Random programs with random stalls and idle gaps
    for (int p = 0; p < 8; p++) begin
      int n;
      start_prog();
      rand_stall = 1;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535), i == n - 1);
      end
      finish_prog();
      rand_stall = 0;
      @(posedge clk);
      #1 imem_stall = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
